// File: rtl/wbs_ctrl.sv
// Wishbone classic slave bridging the Caravel bus to the KD-tree core: register page,
// four SRAM windows, start/done handshake. Optional drop counter: WBS_CTRL_DROP_CNT_EN.
module wbs_ctrl #(
    parameter int MEM_ADDR_W = 14,
    parameter int MEM_LAT    = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  mode_o,
    output logic                  debug_o,
    output logic                  fsm_start_o,
    input  logic                  fsm_busy_i,
    input  logic                  fsm_done_i,
    output logic [3:0]            mem_sel_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, REG_ACK, MEM_WR, MEM_RD, RD_WAIT, ACK} state_t;

    localparam logic [1:0]  CNT_LAST  = 2'(MEM_LAT - 1);
    localparam logic [15:0] OFF_MODE  = 16'h0000;
    localparam logic [15:0] OFF_DEBUG = 16'h0004;
    localparam logic [15:0] OFF_DONE  = 16'h0008;
    localparam logic [15:0] OFF_START = 16'h000C;
    localparam logic [15:0] OFF_BUSY  = 16'h0010;

    state_t                  state_reg;
    logic [1:0]              cnt_reg;
    logic [15:0]             off_reg;
    logic                    we_reg;
    logic                    is_reg_reg;
    logic [31:0]             wdata_reg;
    logic                    mode_reg;
    logic                    debug_reg;
    logic                    done_reg;
    logic                    ack_reg;
    logic [31:0]             rdata_reg;
    logic                    start_reg;
    logic [3:0]              sel_reg;
    logic                    mem_we_reg;
    logic                    mem_re_reg;
    logic [MEM_ADDR_W-1:0]   addr_reg;

    logic                    req;
    logic                    claim;
    logic                    accept;
    logic [3:0]              win;
    logic [3:0]              win_hit;
    logic                    is_reg;
    logic                    mem_ok;
    logic                    drop_evt;
    logic                    start_hit;
    logic                    dbg_clr;
    logic                    done_clr;
    logic [7:0]              drop_cnt;
    logic [31:0]             reg_rdata;
    logic                    unused_sel;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign claim   = (wbs_adr_i[31:20] == 12'h300);
    assign accept  = (state_reg == IDLE) & req & claim;
    assign win     = wbs_adr_i[19:16];
    assign is_reg  = (win == 4'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_win
            assign win_hit[gi] = (win == 4'(gi + 1));
        end
    endgenerate

    // Busy and mode are judged at accept; anything not register-page and not a usable window is dropped.
    assign mem_ok    = (|win_hit) & mode_reg & ~fsm_busy_i;
    assign drop_evt  = accept & ~is_reg & ~mem_ok;
    assign start_hit = wbs_we_i & is_reg & (wbs_adr_i[15:0] == OFF_START) & wbs_dat_i[0]
                     & mode_reg & ~fsm_busy_i;
    assign dbg_clr   = (state_reg == REG_ACK) & we_reg & is_reg_reg & (off_reg == OFF_DEBUG);
    assign done_clr  = (state_reg == REG_ACK) & we_reg & is_reg_reg & (off_reg == OFF_DONE);
    assign unused_sel = ^wbs_sel_i;

    always_comb begin
        reg_rdata = '0;
        case (wbs_adr_i[15:0])
            OFF_MODE:  reg_rdata = {31'd0, mode_reg};
            OFF_DEBUG: reg_rdata = {16'd0, drop_cnt, 7'd0, debug_reg};
            OFF_DONE:  reg_rdata = {31'd0, done_reg};
            OFF_BUSY:  reg_rdata = {31'd0, fsm_busy_i};
            default:   reg_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            off_reg    <= '0;
            we_reg     <= 1'b0;
            is_reg_reg <= 1'b0;
            wdata_reg  <= '0;
            mode_reg   <= 1'b0;
            debug_reg  <= 1'b0;
            ack_reg    <= 1'b0;
            rdata_reg  <= '0;
            start_reg  <= 1'b0;
            sel_reg    <= '0;
            mem_we_reg <= 1'b0;
            mem_re_reg <= 1'b0;
            addr_reg   <= '0;
        end else begin
            // Every strobe, ack and data output is a one-cycle pulse unless re-asserted below.
            ack_reg    <= 1'b0;
            rdata_reg  <= '0;
            start_reg  <= 1'b0;
            sel_reg    <= '0;
            mem_we_reg <= 1'b0;
            mem_re_reg <= 1'b0;
            addr_reg   <= '0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        off_reg    <= wbs_adr_i[15:0];
                        we_reg     <= wbs_we_i;
                        is_reg_reg <= is_reg;
                        wdata_reg  <= wbs_dat_i;
                        if (mem_ok) begin
                            sel_reg  <= win_hit;
                            addr_reg <= wbs_adr_i[MEM_ADDR_W+1:2];
                            if (wbs_we_i) begin
                                mem_we_reg <= 1'b1;
                                state_reg  <= MEM_WR;
                            end else begin
                                mem_re_reg <= 1'b1;
                                state_reg  <= MEM_RD;
                            end
                        end else begin
                            ack_reg   <= 1'b1;
                            rdata_reg <= (is_reg & ~wbs_we_i) ? reg_rdata : 32'd0;
                            start_reg <= start_hit;
                            state_reg <= REG_ACK;
                        end
                    end
                end
                REG_ACK: begin
                    if (we_reg && is_reg_reg) begin
                        if (off_reg == OFF_MODE)  mode_reg  <= wdata_reg[0];
                        if (off_reg == OFF_DEBUG) debug_reg <= wdata_reg[0];
                    end
                    state_reg <= IDLE;
                end
                MEM_WR: begin
                    ack_reg   <= 1'b1;
                    state_reg <= ACK;
                end
                MEM_RD: begin
                    cnt_reg   <= '0;
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt_reg == CNT_LAST) begin
                        ack_reg   <= 1'b1;
                        rdata_reg <= mem_rdata_i;
                        state_reg <= ACK;
                    end else begin
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A done pulse coinciding with a write-clear must survive.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            done_reg <= 1'b0;
        end else if (fsm_done_i) begin
            done_reg <= 1'b1;
        end else if (done_clr) begin
            done_reg <= 1'b0;
        end
    end

`ifdef WBS_CTRL_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            drop_cnt_reg <= '0;
        end else if (dbg_clr) begin
            drop_cnt_reg <= '0;
        end else if (drop_evt && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    logic unused_drop;
    assign unused_drop = drop_evt ^ dbg_clr;
    assign drop_cnt    = 8'd0;
`endif

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = rdata_reg;
    assign mode_o      = mode_reg;
    assign debug_o     = debug_reg;
    assign fsm_start_o = start_reg;
    assign mem_sel_o   = sel_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_re_o    = mem_re_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;

endmodule

// File: tb/tb_wbs_ctrl.sv
// Directed bench for wbs_ctrl with a MEM_LAT=2 SRAM model; one line per bus transaction.
module tb_wbs_ctrl;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_LAT    = 2;

    localparam logic [31:0] A_MODE  = 32'h3000_0000;
    localparam logic [31:0] A_DEBUG = 32'h3000_0004;
    localparam logic [31:0] A_DONE  = 32'h3000_0008;
    localparam logic [31:0] A_START = 32'h3000_000C;
    localparam logic [31:0] A_BUSY  = 32'h3000_0010;

    logic                  clk = 1'b0;
    logic                  srst;
    logic                  wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [31:0]           wbs_adr_i, wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;
    logic                  mode_o, debug_o, fsm_start_o;
    logic                  fsm_busy_i, fsm_done_i;
    logic [3:0]            mem_sel_o;
    logic                  mem_we_o, mem_re_o;
    logic [MEM_ADDR_W-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o, mem_rdata_i;

    logic [1:0]            re_pipe = '0;
    logic [31:0]           model_data = '0;

    int n_chk  = 0;
    int n_pass = 0;

    int                    t_ack_n, t_we_n, t_re_n, t_start_n, t_start_cnt;
    logic [3:0]            t_sel;
    logic [MEM_ADDR_W-1:0] t_addr;
    logic [31:0]           t_wdata, t_rdata;
    logic                  t_leak, t_ack_after, t_rst_outs;
    int                    done_on_n = 0;
    int                    rst_on_n  = 0;

    always #5 clk = ~clk;

    wbs_ctrl #(.MEM_ADDR_W(MEM_ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (srst),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .mode_o      (mode_o),
        .debug_o     (debug_o),
        .fsm_start_o (fsm_start_o),
        .fsm_busy_i  (fsm_busy_i),
        .fsm_done_i  (fsm_done_i),
        .mem_sel_o   (mem_sel_o),
        .mem_we_o    (mem_we_o),
        .mem_re_o    (mem_re_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // SRAM model: data is valid exactly MEM_LAT cycles after the read strobe, junk otherwise.
    always @(posedge clk) re_pipe <= {re_pipe[0], mem_re_o};
    assign mem_rdata_i = re_pipe[MEM_LAT-1] ? model_data : 32'hDEAD_BEEF;

    function automatic logic any_out();
        return |{wbs_ack_o, wbs_dat_o, mode_o, debug_o, fsm_start_o, mem_sel_o,
                 mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Cycle n=1 is the cycle right after the accepting edge; observations are taken on negedges.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        int n;
        bit got;
        t_ack_n = 0; t_we_n = 0; t_re_n = 0; t_start_n = 0; t_start_cnt = 0;
        t_sel = '0; t_addr = '0; t_wdata = '0; t_rdata = '0;
        t_leak = 1'b0; t_ack_after = 1'b0; t_rst_outs = 1'b0;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rst_on_n != 0 && n == rst_on_n) begin
                srst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            if (rst_on_n != 0 && n == rst_on_n + 1) t_rst_outs = any_out();
            if (rst_on_n != 0 && n == rst_on_n + 2) srst = 1'b0;
            fsm_done_i = (n == done_on_n);
            if (mem_we_o) begin
                t_we_n = n; t_sel = mem_sel_o; t_addr = mem_addr_o; t_wdata = mem_wdata_o;
            end
            if (mem_re_o) begin
                t_re_n = n; t_sel = mem_sel_o; t_addr = mem_addr_o;
            end
            if (fsm_start_o) begin
                t_start_cnt++; t_start_n = n;
            end
            if (wbs_ack_o) begin
                t_ack_n = n; t_rdata = wbs_dat_o; got = 1'b1;
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end else if (wbs_dat_o != 32'd0) begin
                t_leak = 1'b1;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        t_ack_after = wbs_ack_o;
        if (fsm_start_o) t_start_cnt++;
        if (wbs_dat_o != 32'd0) t_leak = 1'b1;
        fsm_done_i = 1'b0;
        $display("xfer we=%0d adr=0x%08h dat=0x%08h ack@%0d rdata=0x%08h we@%0d re@%0d start=%0d",
                 we, adr, dat, t_ack_n, t_rdata, t_we_n, t_re_n, t_start_cnt);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        xfer(1'b1, adr, dat);
    endtask

    task automatic rd(input logic [31:0] adr);
        xfer(1'b0, adr, 32'd0);
    endtask

    initial begin
        srst = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = '0; wbs_dat_i = '0; fsm_busy_i = 1'b0; fsm_done_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", 32'(any_out()), 32'd0);
        srst = 1'b0;

        // Register page
        wr(A_MODE, 32'd1);
        chk("mode_wr_ack", t_ack_n, 1);
        chk("mode_o_set", 32'(mode_o), 32'd1);
        rd(A_MODE);
        chk("mode_rd_ack", t_ack_n, 1);
        chk("mode_rd_data", t_rdata, 32'd1);
        rd(A_BUSY);
        chk("busy0_rd_ack", t_ack_n, 1);
        chk("busy0_rd_data", t_rdata, 32'd0);
        fsm_busy_i = 1'b1;
        rd(A_BUSY);
        chk("busy1_rd_data", t_rdata, 32'd1);
        fsm_busy_i = 1'b0;

        // Memory write to node window
        wr(32'h3004_0004, 32'h0037_0001);
        chk("mwr_we_cycle", t_we_n, 1);
        chk("mwr_sel", 32'(t_sel), 32'h8);
        chk("mwr_addr", 32'(t_addr), 32'd1);
        chk("mwr_wdata", t_wdata, 32'h0037_0001);
        chk("mwr_ack_cycle", t_ack_n, 2);
        chk("mwr_no_re", t_re_n, 0);

        // Memory read from best window, latency 2
        model_data = 32'h0000_ABCD;
        rd(32'h3003_0008);
        chk("mrd_re_cycle", t_re_n, 1);
        chk("mrd_sel", 32'(t_sel), 32'h4);
        chk("mrd_addr", 32'(t_addr), 32'd2);
        chk("mrd_ack_cycle", t_ack_n, 4);
        chk("mrd_data", t_rdata, 32'h0000_ABCD);
        chk("mrd_dat_outside_ack", 32'(t_leak), 32'd0);
        chk("mrd_single_ack", 32'(t_ack_after), 32'd0);

        // Dropped accesses: mode off, then busy
        wr(A_MODE, 32'd0);
        wr(32'h3001_0000, 32'h1111_1111);
        chk("drop_mode_no_we", t_we_n, 0);
        chk("drop_mode_ack", t_ack_n, 1);
        wr(A_MODE, 32'd1);
        fsm_busy_i = 1'b1;
        wr(32'h3002_0000, 32'h2222_2222);
        chk("drop_busy_no_we", t_we_n, 0);
        chk("drop_busy_ack", t_ack_n, 1);
        fsm_busy_i = 1'b0;
        rd(A_DEBUG);
`ifdef WBS_CTRL_DROP_CNT_EN
        chk("drop_count_2", t_rdata, 32'h0000_0200);
`else
        chk("drop_count_absent", t_rdata, 32'd0);
`endif
        rd(32'h3007_0000);
        chk("illegal_win_ack", t_ack_n, 1);
        chk("illegal_win_no_re", t_re_n, 0);
        chk("illegal_win_data", t_rdata, 32'd0);
        wr(A_DEBUG, 32'd1);
        chk("debug_o_set", 32'(debug_o), 32'd1);
        rd(A_DEBUG);
        chk("debug_rd_cleared_cnt", t_rdata, 32'd1);

        // Sticky DONE with set-wins-over-clear
        @(negedge clk); fsm_done_i = 1'b1;
        @(negedge clk); fsm_done_i = 1'b0;
        rd(A_DONE);
        chk("done_set", t_rdata, 32'd1);
        wr(A_DONE, 32'd0);
        rd(A_DONE);
        chk("done_cleared", t_rdata, 32'd0);
        done_on_n = 1;
        wr(A_DONE, 32'd0);
        done_on_n = 0;
        rd(A_DONE);
        chk("done_set_wins", t_rdata, 32'd1);
        wr(A_DONE, 32'd0);
        rd(A_DONE);
        chk("done_cleared_again", t_rdata, 32'd0);

        // Start pulse
        wr(A_START, 32'd1);
        chk("start_cycle", t_start_n, 1);
        chk("start_width", t_start_cnt, 1);
        fsm_busy_i = 1'b1;
        wr(A_START, 32'd1);
        chk("start_blocked_busy", t_start_cnt, 0);
        fsm_busy_i = 1'b0;
        wr(A_START, 32'd0);
        chk("start_dat0_ignored", t_start_cnt, 0);

        // Unclaimed page never acks
        rd(32'h2000_0000);
        chk("unclaimed_no_ack", t_ack_n, 0);

        // Reset during RD_WAIT aborts the read
        model_data = 32'h0000_1234;
        rst_on_n = 2;
        rd(32'h3002_0004);
        rst_on_n = 0;
        chk("rst_rd_re_once", t_re_n, 1);
        chk("rst_rd_no_ack", t_ack_n, 0);
        chk("rst_rd_outs_zero", 32'(t_rst_outs), 32'd0);
        chk("rst_mode_cleared", 32'(mode_o), 32'd0);
        wr(A_MODE, 32'd1);
        rd(32'h3002_0004);
        chk("post_rst_rd_ack", t_ack_n, 4);
        chk("post_rst_rd_data", t_rdata, 32'h0000_1234);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
